// File: rtl/onehot_bitmap_builder_pkg.sv
// Shared types and constants for the one-hot bitmap builder.
// FSM encoding and count-width helper.
package onehot_bitmap_builder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width needed to hold a count from 0 to w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/onehot_bitmap_builder_if.sv
// Index-token input stream and bitmap output stream.
// master drives tokens / takes bitmaps, slave is the builder.
interface onehot_bitmap_builder_if #(
    parameter int W = 16
);
    import onehot_bitmap_builder_pkg::*;

    localparam int IDX_W = $clog2(W);
    localparam int CNT_W = cnt_width(W);

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_bitmap;
    logic [CNT_W-1:0] out_count;
    logic             out_dup;
    logic             out_oob;

    modport master (
        output in_valid, in_index, in_last, out_ready,
        input  in_ready, out_valid, out_bitmap,
        input  out_count, out_dup, out_oob
    );

    modport slave (
        input  in_valid, in_index, in_last, out_ready,
        output in_ready, out_valid, out_bitmap,
        output out_count, out_dup, out_oob
    );

endinterface

// File: rtl/onehot_bitmap_builder_decoder.sv
// Index to one-hot decoder, counterpart of the priority encoder.
// Indices >= W decode to all-zero with in_range low.
module onehot_decoder #(
    parameter int W = 16
) (
    input  logic [$clog2(W)-1:0] in_index,
    output logic [W-1:0]         onehot,
    output logic                 in_range
);

    assign in_range = (32'(in_index) < W);
    assign onehot   = in_range ? (W'(1) << in_index) : '0;

endmodule

// File: rtl/onehot_bitmap_builder.sv
// Accumulates index tokens into a W-bit bitmap, one frame per in_last.
// Optional BITMAP_BUILDER_OVERLAP_EN: accept the next frame's first token during the output handshake.
module onehot_bitmap_builder
    import onehot_bitmap_builder_pkg::*;
#(
    parameter int W = 16
) (
    input logic clk,
    input logic rst,
    onehot_bitmap_builder_if.slave bus
);

    localparam int CNT_W = cnt_width(W);

    state_t           state;
    logic [W-1:0]     bitmap;
    logic [CNT_W-1:0] count;
    logic             dup;
    logic             oob;

    logic [W-1:0]     onehot;
    logic             in_range;
    logic             already;
    logic             accept;
    logic             release_out;

    onehot_decoder #(.W(W)) u_dec (
        .in_index (bus.in_index),
        .onehot   (onehot),
        .in_range (in_range)
    );

`ifdef BITMAP_BUILDER_OVERLAP_EN
    assign bus.in_ready = (state == ACCUM) | bus.out_ready;
`else
    assign bus.in_ready = (state == ACCUM);
`endif

    assign bus.out_valid  = (state == HOLD);
    assign bus.out_bitmap = bitmap;
    assign bus.out_count  = count;
    assign bus.out_dup    = dup;
    assign bus.out_oob    = oob;

    assign already     = |(bitmap & onehot);
    assign accept      = bus.in_valid & bus.in_ready;
    assign release_out = bus.out_valid & bus.out_ready;

    // Frame FSM plus bitmap, distinct count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ACCUM;
            bitmap <= '0;
            count  <= '0;
            dup    <= 1'b0;
            oob    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (!in_range) begin
                            oob <= 1'b1;
                        end else if (already) begin
                            dup <= 1'b1;
                        end else begin
                            bitmap <= bitmap | onehot;
                            count  <= count + CNT_W'(1);
                        end
                        if (bus.in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (release_out) begin
`ifdef BITMAP_BUILDER_OVERLAP_EN
                        if (accept) begin
                            bitmap <= onehot;
                            count  <= CNT_W'(in_range);
                            dup    <= 1'b0;
                            oob    <= ~in_range;
                            state  <= bus.in_last ? HOLD : ACCUM;
                        end else begin
                            bitmap <= '0;
                            count  <= '0;
                            dup    <= 1'b0;
                            oob    <= 1'b0;
                            state  <= ACCUM;
                        end
`else
                        bitmap <= '0;
                        count  <= '0;
                        dup    <= 1'b0;
                        oob    <= 1'b0;
                        state  <= ACCUM;
`endif
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_bitmap_builder.sv
// Scoreboard bench: W=16 and W=12 builders share one token stream.
// Frame-level reference model computes expected bitmaps, counts and flags.
module tb_onehot_bitmap_builder;

`ifdef BITMAP_BUILDER_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef struct {
        logic [15:0] bm;
        int          cnt;
        bit          dup;
        bit          oob;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_index = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    bit         rnd_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_bitmap_builder_if #(.W(16)) if16 ();
    onehot_bitmap_builder_if #(.W(12)) if12 ();

    assign if16.in_valid  = in_valid;
    assign if16.in_index  = in_index;
    assign if16.in_last   = in_last;
    assign if16.out_ready = out_ready;
    assign if12.in_valid  = in_valid;
    assign if12.in_index  = in_index;
    assign if12.in_last   = in_last;
    assign if12.out_ready = out_ready;

    onehot_bitmap_builder #(.W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    onehot_bitmap_builder #(.W(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (if12)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame result straight from the definition: set of in-range indices.
    function automatic res_t model(input int idx[$], input int w);
        res_t r;
        bit   seen [16];
        r = '{bm: '0, cnt: 0, dup: 1'b0, oob: 1'b0};
        foreach (seen[k]) seen[k] = 1'b0;
        foreach (idx[k]) begin
            if (idx[k] >= w) r.oob = 1'b1;
            else if (seen[idx[k]]) r.dup = 1'b1;
            else seen[idx[k]] = 1'b1;
        end
        foreach (seen[k]) if (seen[k]) r.bm[k] = 1'b1;
        r.cnt = $countones(r.bm);
        return r;
    endfunction

    int   frame [$];
    res_t q16 [$];
    res_t q12 [$];
    bit   holding = 1'b0;

    // Monitor: compares every cycle against the model, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            frame.delete();
            q16.delete();
            q12.delete();
            holding = 1'b0;
        end else begin
            bit   er;
            bit   acc;
            res_t p16;
            res_t p12;
            er = holding ? (OVERLAP && out_ready) : 1'b1;
            chk("in_ready16", 32'(if16.in_ready), 32'(er));
            chk("in_ready12", 32'(if12.in_ready), 32'(er));
            chk("out_valid16", 32'(if16.out_valid), 32'(holding));
            chk("out_valid12", 32'(if12.out_valid), 32'(holding));
            if (holding && q16.size() > 0 && q12.size() > 0) begin
                p16 = q16[0];
                p12 = q12[0];
            end else begin
                p16 = model(frame, 16);
                p12 = model(frame, 12);
            end
            chk("bitmap16", 32'(if16.out_bitmap), 32'(p16.bm));
            chk("count16", 32'(if16.out_count), p16.cnt);
            chk("dup16", 32'(if16.out_dup), 32'(p16.dup));
            chk("oob16", 32'(if16.out_oob), 32'(p16.oob));
            chk("bitmap12", 32'(if12.out_bitmap), 32'(p12.bm[11:0]));
            chk("count12", 32'(if12.out_count), p12.cnt);
            chk("dup12", 32'(if12.out_dup), 32'(p12.dup));
            chk("oob12", 32'(if12.out_oob), 32'(p12.oob));
            acc = in_valid && er;
            if (holding && out_ready) begin
                if (q16.size() > 0) void'(q16.pop_front());
                if (q12.size() > 0) void'(q12.pop_front());
                holding = 1'b0;
            end
            if (acc) begin
                frame.push_back(int'(in_index));
                if (in_last) begin
                    q16.push_back(model(frame, 16));
                    q12.push_back(model(frame, 12));
                    frame.delete();
                    holding = 1'b1;
                end
            end
        end
    end

    task automatic send(input int idx, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_index = 4'(idx);
        in_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!if16.in_ready && n < 50);
        if (!if16.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(if16.out_valid), 0);
        chk({tag, "_ready"}, 32'(if16.in_ready), 1);
        chk({tag, "_bm16"}, 32'(if16.out_bitmap), 0);
        chk({tag, "_cnt16"}, 32'(if16.out_count), 0);
        chk({tag, "_flags16"}, {30'b0, if16.out_dup, if16.out_oob}, 0);
        chk({tag, "_bm12"}, 32'(if12.out_bitmap), 0);
        chk({tag, "_flags12"}, {30'b0, if12.out_dup, if12.out_oob}, 0);
    endtask

    // Random backpressure on the output side during the random phase.
    initial begin
        wait (rnd_mode);
        while (rnd_mode) begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        // Reset with a token pending.
        rst = 1'b1;
        in_valid = 1'b1;
        in_index = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("reset");

        // Basic frame 3,7,15.
        out_ready = 1'b1;
        send(3, 1'b0);
        send(7, 1'b0);
        send(15, 1'b1);
        chk("basic_valid", 32'(if16.out_valid), 1);
        chk("basic_bm", 32'(if16.out_bitmap), 32'h8088);
        chk("basic_cnt", 32'(if16.out_count), 3);
        chk("basic_dup", 32'(if16.out_dup), 0);
        @(posedge clk);
        #1;
        chk("basic_clear", 32'(if16.out_bitmap), 0);

        // Duplicate.
        send(5, 1'b0);
        send(5, 1'b1);
        chk("dup_bm", 32'(if16.out_bitmap), 32'h0020);
        chk("dup_cnt", 32'(if16.out_count), 1);
        chk("dup_flag", 32'(if16.out_dup), 1);
        @(posedge clk);
        #1;

        // Backpressure.
        out_ready = 1'b0;
        send(0, 1'b1);
        repeat (4) begin
            chk("bp_valid", 32'(if16.out_valid), 1);
            chk("bp_bm", 32'(if16.out_bitmap), 32'h0001);
            chk("bp_ready", 32'(if16.in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", 32'(if16.in_ready), 1);
        chk("bp_release_valid", 32'(if16.out_valid), 0);

        // Out-of-range index on the W=12 builder.
        send(13, 1'b0);
        send(2, 1'b1);
        chk("oob_bm12", 32'(if12.out_bitmap), 32'h004);
        chk("oob_cnt12", 32'(if12.out_count), 1);
        chk("oob_flag12", 32'(if12.out_oob), 1);
        chk("oob_bm16", 32'(if16.out_bitmap), 32'h2004);
        @(posedge clk);
        #1;

        // Reset mid-frame.
        send(13, 1'b0);
        send(2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("midrst");

        if (OVERLAP) begin
            out_ready = 1'b0;
            send(1, 1'b1);
            chk("ovl_first", 32'(if16.out_bitmap), 32'h0002);
            out_ready = 1'b1;
            send(4, 1'b1);
            chk("ovl_valid", 32'(if16.out_valid), 1);
            chk("ovl_second", 32'(if16.out_bitmap), 32'h0010);
            chk("ovl_cnt", 32'(if16.out_count), 1);
            @(posedge clk);
            #1;
        end

        // Randomized frames with random gaps and backpressure.
        rnd_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end
        send(int'($urandom_range(0, 15)), 1'b1);
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_valid", 32'(if16.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
